// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and instruction-RAM signals around the imem port arbiter.
// The master side drives requests and RAM read data. The slave side is the arbiter.
interface imem_port_arbiter_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [31:0]   if_instr_o;

  logic          ld_req_i;
  logic [31:0]   ld_addr_i;
  logic [31:0]   ld_data_i;
  logic          ld_gnt_o;

  logic          err_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  modport master (
    output if_req_i, if_addr_i, ld_req_i, ld_addr_i, ld_data_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_instr_o, ld_gnt_o, err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  if_req_i, if_addr_i, ld_req_i, ld_addr_i, ld_data_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_instr_o, ld_gnt_o, err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous-read instruction RAM between IF fetch and the program loader.
// The loader has priority, with starvation relief for fetch. Reads return with 1-cycle latency.
module imem_port_arbiter #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  imem_port_arbiter_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve_cnt;
  logic          r_rd_pend;
  logic          r_bad_rd;
  logic          r_err;

  logic [CW-1:0] w_starve_nxt;
  logic          w_if_gnt;
  logic          w_ld_gnt;
  logic          w_if_bad;
  logic          w_ld_bad;
  logic          w_bad;
  logic          w_gnt_any;
  logic [AW-1:0] w_word;

  // Misaligned, or beyond the end of the RAM.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  assign w_if_bad = addr_bad(bus.if_addr_i);
  assign w_ld_bad = addr_bad(bus.ld_addr_i);

  // Grants are forced low while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ld_gnt = 1'b0;
    if (rst_i) begin
      w_if_gnt = bus.if_req_i && (!bus.ld_req_i || (r_starve_cnt == STARVE_LIM));
      w_ld_gnt = bus.ld_req_i && !w_if_gnt;
    end
  end

  assign w_gnt_any = w_if_gnt | w_ld_gnt;
  assign w_bad     = w_ld_gnt ? w_ld_bad : w_if_bad;
  assign w_word    = w_ld_gnt ? bus.ld_addr_i[AW+1:2] : bus.if_addr_i[AW+1:2];

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.ld_gnt_o    = w_ld_gnt;
  assign bus.mem_en_o    = w_gnt_any & ~w_bad;
  assign bus.mem_we_o    = w_ld_gnt & ~w_ld_bad;
  assign bus.mem_addr_o  = (w_gnt_any & ~w_bad) ? w_word : '0;
  assign bus.mem_wdata_o = (w_ld_gnt & ~w_ld_bad) ? bus.ld_data_i : 32'h0;

  // Counts fetch cycles lost to the loader; resets once fetch is served or withdraws.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!bus.if_req_i || w_if_gnt) begin
      w_starve_nxt = '0;
    end else if (w_ld_gnt && (r_starve_cnt != STARVE_LIM)) begin
      w_starve_nxt = r_starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_bad_rd     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_rd_pend    <= w_if_gnt & ~w_if_bad;
      r_bad_rd     <= w_if_gnt & w_if_bad;
      r_err        <= w_gnt_any & w_bad;
    end
  end

  // A bad fetch still completes, returning a NOP (all zeros).
  assign bus.if_rvalid_o = r_rd_pend | r_bad_rd;
  assign bus.if_instr_o  = r_rd_pend ? bus.mem_rdata_i : 32'h0;
  assign bus.err_o       = r_err;

endmodule
